// File: rtl/crc_stream_chk.sv
// Streaming CRC checker: a one-stage registered valid/ready pipeline that accumulates a CRC
// per frame and checks it against crc_in on the last beat, with per-frame status and counters.
module crc_stream_chk #(
  parameter int unsigned                 DATA_WIDTH = 8,
  parameter int unsigned                 CRC_WIDTH  = 8,
  parameter logic [CRC_WIDTH-1:0]        POLY       = 'h07,
  parameter logic [CRC_WIDTH-1:0]        CRC_INIT   = '0,
  parameter int unsigned                 CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [CRC_WIDTH-1:0]  crc_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  frame_done,
  output logic                  err_detected,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  input  logic                  clr_cnt
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                state_q, state_d;
  logic [CRC_WIDTH-1:0]  crc_q, crc_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;

  logic                  accept;
  logic                  done;
  logic                  mismatch;
  logic [CRC_WIDTH-1:0]  crc_start;
  logic [CRC_WIDTH-1:0]  crc_calc;
  logic                  fb;
  logic [CNT_WIDTH-1:0]  err_base;
  logic [CNT_WIDTH-1:0]  frame_base;

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign done     = accept & in_last;

  // Bit-serial CRC over one beat, MSB first; a new frame starts from CRC_INIT.
  always_comb begin
    crc_start = (state_q == StIdle) ? CRC_INIT : crc_q;
    crc_calc  = crc_start;
    fb        = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb       = crc_calc[CRC_WIDTH-1] ^ in_data[i];
      crc_calc = {crc_calc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  assign mismatch = (crc_calc != crc_in);

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    if (accept) begin
      if (in_last) begin
        state_d = StIdle;
        crc_d   = CRC_INIT;
      end else begin
        state_d = StBusy;
        crc_d   = crc_calc;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_last_d  = in_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // A clear and a completion in the same cycle count the completing frame on top of zero.
  always_comb begin
    frame_done_d = done;
    err_d        = done ? mismatch : err_q;
    err_base     = clr_cnt ? '0 : err_cnt_q;
    frame_base   = clr_cnt ? '0 : frame_cnt_q;
    frame_cnt_d  = frame_base;
    err_cnt_d    = err_base;
    if (done) begin
      frame_cnt_d = frame_base + CNT_WIDTH'(1);
      if (mismatch && (err_base != '1)) begin
        err_cnt_d = err_base + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      crc_q        <= CRC_INIT;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign frame_done   = frame_done_q;
  assign err_detected = err_q;
  assign err_cnt      = err_cnt_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_crc_stream_chk.sv
// Bench for crc_stream_chk: two instances (8-bit and 2-bit counters) share stimulus and are
// compared every cycle against a frame-level model using polynomial long division.
module tb_crc_stream_chk;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic [7:0] crc_in = '0;
  logic       out_ready = 1'b1;
  logic       clr_cnt = 1'b0;

  logic       in_ready, out_valid, out_last, frame_done, err_detected;
  logic [7:0] out_data, err_cnt, frame_cnt;
  logic       in_ready2, out_valid2, out_last2, frame_done2, err_detected2;
  logic [7:0] out_data2;
  logic [1:0] err_cnt2, frame_cnt2;

  always #5 clk = ~clk;

  crc_stream_chk #(
    .DATA_WIDTH(8), .CRC_WIDTH(8), .POLY(8'h07), .CRC_INIT(8'h00), .CNT_WIDTH(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .crc_in(crc_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .frame_done(frame_done),
    .err_detected(err_detected), .err_cnt(err_cnt), .frame_cnt(frame_cnt), .clr_cnt(clr_cnt)
  );

  crc_stream_chk #(
    .DATA_WIDTH(8), .CRC_WIDTH(8), .POLY(8'h07), .CRC_INIT(8'h00), .CNT_WIDTH(2)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_last(in_last), .crc_in(crc_in), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_last(out_last2), .frame_done(frame_done2),
    .err_detected(err_detected2), .err_cnt(err_cnt2), .frame_cnt(frame_cnt2), .clr_cnt(clr_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  bit          m_valid, m_last, m_done, m_err;
  logic [7:0]  m_data;
  int unsigned m_frames, m_err8, m_err2;
  logic [7:0]  frame_q[$];

  bit          rnd_ready = 1'b0;
  bit          last_acc;
  bit          started = 1'b0;
  int          pulses = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  s9[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC as remainder of M(x)*x^8 divided by x^8 + x^2 + x + 1.
  function automatic logic [7:0] crc_of(input logic [7:0] b[$]);
    logic [7:0] r;
    logic [8:0] r9;
    logic       d;
    r = '0;
    for (int n = 0; n <= b.size(); n++) begin
      for (int i = 7; i >= 0; i--) begin
        d  = (n < b.size()) ? b[n][i] : 1'b0;
        r9 = {r, d};
        if (r9[8]) r9 = r9 ^ 9'h107;
        r  = r9[7:0];
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      if (!rst_n) begin
        check("rst_out_valid", {out_valid, out_valid2}, 0);
        check("rst_out_data", {out_data, out_data2}, 0);
        check("rst_out_last", {out_last, out_last2}, 0);
        check("rst_frame_done", {frame_done, frame_done2}, 0);
        check("rst_err_detected", {err_detected, err_detected2}, 0);
        check("rst_counters", {err_cnt, frame_cnt, err_cnt2, frame_cnt2}, 0);
      end else begin
        check("in_ready", {in_ready, in_ready2}, {2{!m_valid || out_ready}});
        check("out_valid", {out_valid, out_valid2}, {2{m_valid}});
        if (m_valid) begin
          check("out_data", {out_data, out_data2}, {m_data, m_data});
          check("out_last", {out_last, out_last2}, {2{m_last}});
        end
        check("frame_done", {frame_done, frame_done2}, {2{m_done}});
        check("err_detected", {err_detected, err_detected2}, {2{m_err}});
        check("frame_cnt8", frame_cnt, m_frames % 256);
        check("err_cnt8", err_cnt, m_err8);
        check("frame_cnt2", frame_cnt2, m_frames % 4);
        check("err_cnt2", err_cnt2, m_err2);
        if (frame_done) pulses++;
      end
    end
  end

  task automatic tick();
    bit         acc;
    bit         mism;
    logic [7:0] c;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    acc = in_valid && (!m_valid || out_ready);
    if (out_valid && out_ready) rx_q.push_back(out_data);
    last_acc = acc;
    @(posedge clk);
    m_done = 1'b0;
    if (clr_cnt) begin
      m_frames = 0;
      m_err8   = 0;
      m_err2   = 0;
    end
    if (acc) begin
      frame_q.push_back(in_data);
      m_valid = 1'b1;
      m_data  = in_data;
      m_last  = in_last;
      if (in_last) begin
        c      = crc_of(frame_q);
        mism   = (c !== crc_in);
        m_done = 1'b1;
        m_err  = mism;
        m_frames++;
        if (mism) begin
          if (m_err8 < 255) m_err8++;
          if (m_err2 < 3) m_err2++;
        end
        frame_q.delete();
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    m_valid  = 0; m_last = 0; m_done = 0; m_err = 0; m_data = '0;
    m_frames = 0; m_err8 = 0; m_err2 = 0;
    frame_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic [7:0] c);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    crc_in   = c;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) check("accept_timeout", {31'd0, last_acc}, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b[$], input logic [7:0] c, input bit gaps);
    for (int i = 0; i < b.size(); i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send(b[i], i == b.size() - 1, c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] one[$];
    logic [7:0] fb[$];
    logic [7:0] c;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    started = 1'b1;
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    one = '{8'h01};
    check("pin_crc_check_string", crc_of(s9), 8'hF4);
    check("pin_crc_01", crc_of(one), 8'h07);

    // Single-beat frame
    do_reset();
    send(8'h01, 1'b1, 8'h07);
    check("t1_frame_done", frame_done, 1);
    check("t1_err", err_detected, 0);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_out_data", out_data, 8'h01);
    check("t1_out_last", out_last, 1);

    // Nine-beat check string, good then bad CRC
    do_reset();
    send_frame(s9, 8'hF4, 1'b0);
    check("t2_good_err", err_detected, 0);
    send_frame(s9, 8'hF5, 1'b0);
    check("t2_bad_err", err_detected, 1);
    check("t2_err_cnt", err_cnt, 1);
    check("t2_frame_cnt", frame_cnt, 2);

    // Gaps and backpressure
    do_reset();
    idle(1);
    rx_q.delete();
    pulses = 0;
    rnd_ready = 1'b1;
    send_frame(s9, 8'hF4, 1'b1);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(3);
    check("t3_rx_count", rx_q.size(), 9);
    for (int i = 0; i < 9; i++) check($sformatf("t3_rx_%0d", i), rx_q[i], s9[i]);
    check("t3_pulses", pulses, 1);
    check("t3_err", err_detected, 0);

    // Reset mid-frame
    do_reset();
    pulses = 0;
    for (int i = 0; i < 4; i++) send(s9[i], 1'b0, 8'h00);
    idle(2);
    check("t4_partial_pulses", pulses, 0);
    do_reset();
    send_frame(s9, 8'hF4, 1'b0);
    idle(1);
    check("t4_err", err_detected, 0);
    check("t4_frame_cnt", frame_cnt, 1);
    check("t4_pulses", pulses, 1);

    // Saturation on the 2-bit instance, then clear coinciding with a bad frame
    do_reset();
    repeat (5) send(8'h00, 1'b1, 8'h01);
    check("t5_err_cnt2_sat", err_cnt2, 3);
    check("t5_frame_cnt2_wrap", frame_cnt2, 1);
    clr_cnt = 1'b1;
    send(8'h00, 1'b1, 8'h01);
    clr_cnt = 1'b0;
    check("t5_clr_err_cnt2", err_cnt2, 1);
    check("t5_clr_frame_cnt2", frame_cnt2, 1);
    check("t5_clr_err_cnt8", err_cnt, 1);
    check("t5_clr_frame_cnt8", frame_cnt, 1);

    // Back-to-back single-beat frames
    do_reset();
    out_ready = 1'b1;
    check("t6_in_ready_a", in_ready, 1);
    send(8'h00, 1'b1, 8'h00);
    check("t6_done_a", frame_done, 1);
    check("t6_err_a", err_detected, 0);
    check("t6_in_ready_b", in_ready, 1);
    send(8'h01, 1'b1, 8'h00);
    check("t6_done_b", frame_done, 1);
    check("t6_err_b", err_detected, 1);
    check("t6_in_ready_c", in_ready, 1);

    // Random frames, gaps, backpressure and clears
    do_reset();
    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int nb;
      nb = $urandom_range(1, 5);
      fb.delete();
      for (int i = 0; i < nb; i++) fb.push_back(8'($urandom));
      c = crc_of(fb);
      if ($urandom_range(0, 1) == 1) c = c ^ 8'($urandom_range(1, 255));
      for (int i = 0; i < nb; i++) begin
        idle($urandom_range(0, 2));
        clr_cnt = (i == nb - 1) && ($urandom_range(0, 7) == 0);
        send(fb[i], i == nb - 1, c);
        clr_cnt = 1'b0;
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
